booth_mul_seq: RTL

Sequential signed two's-complement multiplier for the datapath ALU, built around the 32-bit add/subtract path. It runs radix-2 Booth recoding and does one conditional add or subtract plus an arithmetic shift per clock. It produces a 64-bit product split into HI and LO words for the Z/HI/LO result registers. Control uses a start/busy/done handshake driven by the control unit's MUL step.

---
 rtl/booth_mul_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential signed Booth multiplier producing a 2*WIDTH-bit
// product as prod_hi/prod_lo. The default build retires one radix-2 Booth step
// per clock. Defining MUL_RADIX4_EN switches to radix-4 steps, which halves the
// number of RUN cycles.
//
// Ports:
//   clock        in   system clock, rising edge
//   clear        in   synchronous active-high reset; takes priority over start
//   start        in   request a multiply; only accepted in IDLE or DONE
//   multiplicand in   signed operand M; captured on the accepting edge
//   multiplier   in   signed operand Q; captured on the accepting edge
//   busy         out  high while the iteration is running
//   done         out  one-cycle completion pulse; product valid from here on
//   prod_hi      out  upper WIDTH bits of the product
//   prod_lo      out  lower WIDTH bits of the product
module booth_mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

`ifdef MUL_RADIX4_EN
  // The extra guard bits let the accumulator hold +/-2M.
  localparam int unsigned AW    = WIDTH + 2;
  localparam int unsigned STEPS = WIDTH / 2;
  localparam int unsigned SH    = 2;
`else
  // The extra guard bit lets -M be represented when M = -2^(WIDTH-1).
  localparam int unsigned AW    = WIDTH + 1;
  localparam int unsigned STEPS = WIDTH;
  localparam int unsigned SH    = 1;
`endif
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = AW + WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      a_q, a_d;
  logic [AW-1:0]      m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [AW-1:0]      a_sum;
  logic signed [PW-1:0] pair_shift;
  logic [AW-1:0]      a_next;
  logic [WIDTH-1:0]   q_next;
  logic               q1_next;

  // One Booth step: recode the low multiplier bits, add the selected multiple
  // of M, then arithmetic-shift the {A,Q,q_1} pair right.
  always_comb begin
    a_sum = a_q;
`ifdef MUL_RADIX4_EN
    case ({q_q[1:0], q1_q})
      3'b001, 3'b010: a_sum = a_q + m_q;
      3'b011:         a_sum = a_q + (m_q << 1);
      3'b100:         a_sum = a_q - (m_q << 1);
      3'b101, 3'b110: a_sum = a_q - m_q;
      default:        a_sum = a_q;
    endcase
`else
    case ({q_q[0], q1_q})
      2'b01:   a_sum = a_q + m_q;
      2'b10:   a_sum = a_q - m_q;
      default: a_sum = a_q;
    endcase
`endif
    pair_shift = $signed({a_sum, q_q}) >>> SH;
    a_next     = pair_shift[PW-1:WIDTH];
    q_next     = pair_shift[WIDTH-1:0];
    q1_next    = q_q[SH-1];
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          m_d     = {{(AW-WIDTH){multiplicand[WIDTH-1]}}, multiplicand};
          q_d     = multiplier;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = CW'(STEPS);
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_next;
        q_d   = q_next;
        q1_d  = q1_next;
        cnt_d = cnt_q - CW'(1);
        // Last step: publish the product only once it is complete.
        if (cnt_q == CW'(1)) begin
          hi_d    = a_next[WIDTH-1:0];
          lo_d    = q_next;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign prod_hi = hi_q;
  assign prod_lo = lo_q;

endmodule
